// File: rtl/fft_input_buffer.sv
// Ping-pong frame buffer feeding the FFT core over valid/ready, one frame of NFFT samples per bank.
// Define FFT_INPUT_BITREV_EN to read each frame out in bit-reversed (butterfly input) order.
module fft_input_buffer #(
  parameter int NFFT      = 512,
  parameter int NFFT_LOG2 = 9,
  parameter int SAMPLE_W  = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 advance,
  input  logic [SAMPLE_W-1:0]  adc_in,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [SAMPLE_W-1:0]  out_data,
  output logic [NFFT_LOG2-1:0] out_index,
  output logic                 out_last,
  output logic [7:0]           overrun_count,
  output logic                 draining
);

  typedef enum logic [1:0] {IDLE, READ, STREAM} state_t;

  localparam logic [NFFT_LOG2-1:0] LAST_K = NFFT_LOG2'(NFFT - 1);

  state_t                 state_reg;
  logic                   adv_d_reg;
  logic                   fill_bank_reg;
  logic [NFFT_LOG2-1:0]   fill_cnt_reg;
  logic [NFFT_LOG2-1:0]   k_reg;
  logic [NFFT_LOG2-1:0]   rd_addr;

  // Both banks live in one array; the top address bit is the bank select.
  logic [SAMPLE_W-1:0]    mem [0:2*NFFT-1];

  logic sample_stb;
  logic frame_done;
  logic last_xfer;
  logic drain_idle;
  logic swap;

  assign sample_stb = advance & ~adv_d_reg;
  assign frame_done = sample_stb && (fill_cnt_reg == LAST_K);
  assign last_xfer  = (state_reg == STREAM) && out_ready && (k_reg == LAST_K);
  assign drain_idle = (state_reg == IDLE) || last_xfer;
  assign swap       = frame_done && drain_idle;
  assign draining   = (state_reg != IDLE);

`ifdef FFT_INPUT_BITREV_EN
  for (genvar gi = 0; gi < NFFT_LOG2; gi++) begin : g_bitrev
    assign rd_addr[gi] = k_reg[NFFT_LOG2-1-gi];
  end
`else
  assign rd_addr = k_reg;
`endif

  always_ff @(posedge clk) begin
    if (!reset && sample_stb)
      mem[{fill_bank_reg, fill_cnt_reg}] <= adc_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      adv_d_reg     <= 1'b0;
      fill_bank_reg <= 1'b0;
      fill_cnt_reg  <= '0;
      k_reg         <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_index     <= '0;
      out_last      <= 1'b0;
      overrun_count <= 8'd0;
    end else begin
      adv_d_reg <= advance;

      if (sample_stb)
        fill_cnt_reg <= fill_cnt_reg + 1'b1;

      // A frame finishing while the previous one is still draining is dropped;
      // the fill bank is reused for the next frame.
      if (frame_done && !drain_idle && overrun_count != 8'hFF)
        overrun_count <= overrun_count + 8'd1;

      if (swap)
        fill_bank_reg <= ~fill_bank_reg;

      case (state_reg)
        IDLE: begin
          if (swap) begin
            state_reg <= READ;
            k_reg     <= '0;
          end
        end
        READ: begin
          out_data  <= mem[{~fill_bank_reg, rd_addr}];
          out_index <= k_reg;
          out_last  <= (k_reg == LAST_K);
          out_valid <= 1'b1;
          state_reg <= STREAM;
        end
        STREAM: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (k_reg == LAST_K) begin
              // Back-to-back frames: the next swap may land on the final beat.
              if (swap) begin
                state_reg <= READ;
                k_reg     <= '0;
              end else begin
                state_reg <= IDLE;
              end
            end else begin
              k_reg     <= k_reg + 1'b1;
              state_reg <= READ;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fft_input_buffer.md
# fft_input_buffer

Ping-pong frame buffer between the audio codec driver and the FFT core. Captures one 24-bit ADC sample per rising edge of the driver's `advance` strobe into the fill bank. When `NFFT` samples are collected, swaps banks and streams the completed frame to the FFT over a valid/ready interface. Readout is optionally in bit-reversed (butterfly input) order.

## Interface
- `NFFT`, 512, samples per frame; power of two, ≥ 4
- `NFFT_LOG2`, 9, log2(`NFFT`)
- `SAMPLE_W`, 24, sample width (matches codec ADC output)
- `clk`  in  1  system clock (`CLOCK_50` domain)
- `reset`  in  1  synchronous, active-high reset
- `advance`  in  1  sample strobe level from audio driver, synchronous to `clk`
- `adc_in`  in  `SAMPLE_W`  sample from driver (left channel), valid when `advance` rises
- `out_ready`  in  1  FFT accepts a beat
- `out_valid`  out  1  `out_data`/`out_index`/`out_last` valid
- `out_data`  out  `SAMPLE_W`  sample for current beat
- `out_index`  out  `NFFT_LOG2`  beat position k within frame, 0..NFFT-1
- `out_last`  out  1  high with the k = NFFT-1 beat
- `overrun_count`  out  8  saturating count of dropped frames
- `draining`  out  1  drain bank holds an unsent or partly sent frame

## Operation
- Storage: two banks of `NFFT` × `SAMPLE_W`. Bank select bit `fill_bank` (reset 0); the drain bank is `~fill_bank`.
- Capture: `adv_d` registers `advance`. `sample_stb = advance & ~adv_d`. On `sample_stb`, write `adc_in` to fill bank at `fill_cnt`, then `fill_cnt` += 1. Widths: `fill_cnt` is `NFFT_LOG2` bits and wraps to 0 after NFFT-1.
- Frame complete: the cycle that writes address NFFT-1 is the swap check.
  - Drain idle (state IDLE, or the final `out_last` beat transfers in the same cycle): toggle `fill_bank`, start drain.
  - Drain busy: frame dropped. `fill_bank` unchanged. The next frame overwrites the same bank. `overrun_count` += 1, saturating at 255.
- Drain FSM:
  - IDLE → READ on swap.
  - READ: issue synchronous RAM read at address `rd_addr(k)`, 1-cycle latency → STREAM.
  - STREAM: `out_valid`=1. On `out_valid & out_ready`: if k = NFFT-1 → IDLE, else k += 1 → READ.
  - Pipelined option not required. One beat per 2 cycles max (≥ 25 M beats/s ≫ audio rate).
- `out_data`, `out_index`, `out_last` are held stable while `out_valid & ~out_ready`.
- `draining` = (state ≠ IDLE).
- Reset mid-frame: partial fill discarded, drain aborted, `out_valid` drops the cycle after `reset`; no partial frame is ever resumed.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_index`=0, `out_last`=0, `overrun_count`=0, `draining`=0. Internal `fill_cnt`=0, `adv_d`=0, state IDLE.
- `advance` held high for multiple cycles produces one sample. A rise in the first cycle after reset deassertion is captured.
- Swap on cycle T (final write) → `draining`=1 at T+1 → `out_valid`=1 at T+2 with k=0.
- After a transfer at cycle C (not last): `out_valid`=0 at C+1, `out_valid`=1 at C+2 with k+1.
- A sample strobe coinciding with any drain activity is always captured. Fill and drain never touch the same bank.

## Configuration
- `FFT_INPUT_BITREV_EN` defined: `rd_addr(k)` = bit-reverse of k over `NFFT_LOG2` bits. The FFT receives butterfly-ordered input and needs no shuffle ROM.
- Undefined: `rd_addr(k)` = k (natural order). The FFT applies its own input-index shuffle.
- In both cases `out_index` = k (beat position), not the RAM address.

## Test plan
- NFFT=8, macro undefined, `out_ready`=1: feed samples 0x000010..0x000017 → 8 beats with `out_data` 0x10..0x17, `out_index` 0..7, `out_last` only on index 7, first `out_valid` 2 cycles after 8th strobe.
- NFFT=8, `FFT_INPUT_BITREV_EN` defined, same stimulus → `out_data` order 0x10,0x14,0x12,0x16,0x11,0x15,0x13,0x17.
- `out_ready`=0 for 20 cycles mid-frame at k=3 → outputs frozen at k=3 data; resume yields k=4 with no loss or duplicate.
- `out_ready`=0 throughout while 16 samples arrive → frame 2 dropped, `overrun_count`=1. Releasing `out_ready` streams frame 1 intact; frame 3 is then delivered.
- `advance` held high 5 cycles per sample → exactly one capture per rise. Last beat accepted on the same cycle as the next frame's final write → swap occurs, `overrun_count` unchanged.
- `reset` pulsed at k=5 during drain and with `fill_cnt`=3 → all outputs 0 next cycle. The next 8 samples form a clean frame starting at index 0.
